// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: FSM encoding, allowed
// bits-per-cycle set, and step/counter sizing helpers.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BPC   = 1;

    // Only 1, 2 or 4 multiplier bits may be retired per cycle.
    function automatic bit bpc_allowed(input int bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4);
    endfunction

    // STEPS = WIDTH/BPC
    function automatic int mul_steps(input int width, input int bpc);
        return width / bpc;
    endfunction

    // CNT_W = $clog2(STEPS), kept at least 1 bit wide for the STEPS == 1 case
    function automatic int mul_cnt_w(input int width, input int bpc);
        int steps;
        steps = width / bpc;
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative signed/unsigned WIDTH x WIDTH -> 2*WIDTH multiplier retiring BPC
// multiplier bits per cycle, with valid/ready handshakes and a pipeline flush.
module mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BPC   = DEF_BPC
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sign,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    input  logic               flush
);

    localparam int STEPS = mul_steps(WIDTH, BPC);
    localparam int CNT_W = mul_cnt_w(WIDTH, BPC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    if (!bpc_allowed(BPC) || (WIDTH % BPC) != 0 || WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_params
        $error("mul_iter: illegal WIDTH=%0d / BPC=%0d", WIDTH, BPC);
    end

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] sum_final;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               accept;
    logic               last_step;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_ready & in_valid & ~flush;
    assign last_step = (cnt == LAST);

    // The most-negative operand maps to 2^(WIDTH-1), which is the correct magnitude.
    assign abs_a = (sign & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign abs_b = (sign & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // Partial-product adder: add the multiplicand, pre-shifted to the current
    // weight, once for each set bit among the BPC low multiplier bits.
    always_comb begin
        sum = acc;
        for (int i = 0; i < BPC; i++) begin
            if (mplier[i]) begin
                sum = sum + (mcand << i);
            end
        end
        sum_final = neg ? (~sum + (2*WIDTH)'(1)) : sum;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_CALC;
            ST_CALC: if (last_step) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mplier <= abs_b;
                mcand  <= {{WIDTH{1'b0}}, abs_a};
                acc    <= '0;
                cnt    <= '0;
                neg    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (state == ST_CALC && !flush) begin
                acc    <= sum;
                mcand  <= mcand << BPC;
                mplier <= mplier >> BPC;
                cnt    <= cnt + CNT_W'(1);
                if (last_step) begin
                    result <= sum_final;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed WIDTH=32/BPC=1 scenarios and a
// randomized WIDTH=16/BPC=4 run against a plain-arithmetic reference model.
module tb_mul_iter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // WIDTH=32, BPC=1 instance
    logic        iv32, ir32, s32, ov32, or32, fl32;
    logic [31:0] a32, b32;
    logic [63:0] res32;

    // WIDTH=16, BPC=4 instance
    logic        iv16, ir16, s16, ov16, or16, fl16;
    logic [15:0] a16, b16;
    logic [31:0] res16;

    mul_iter #(.WIDTH(32), .BPC(1)) u_mul32 (
        .clk(clk), .resetn(resetn),
        .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .sign(s32),
        .out_valid(ov32), .out_ready(or32), .result(res32), .flush(fl32)
    );

    mul_iter #(.WIDTH(16), .BPC(4)) u_mul16 (
        .clk(clk), .resetn(resetn),
        .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sign(s16),
        .out_valid(ov16), .out_ready(or16), .result(res16), .flush(fl16)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: extend each operand to full product width by its signedness,
    // multiply, keep the low 2W bits.
    function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] ex, ey;
        ex = s ? {{32{x[31]}}, x} : {32'h0, x};
        ey = s ? {{32{y[31]}}, y} : {32'h0, y};
        return ex * ey;
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [31:0] ex, ey;
        ex = s ? {{16{x[15]}}, x} : {16'h0, x};
        ey = s ? {{16{y[15]}}, y} : {16'h0, y};
        return ex * ey;
    endfunction

    // Issue one request; scramble operands after acceptance; count edges to out_valid.
    task automatic run32(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         input bit handshake, output logic [63:0] r, output int lat);
        int guard = 0;
        while (!ir32 && guard < 100) begin @(posedge clk); #1; guard++; end
        iv32 = 1'b1; a32 = av; b32 = bv; s32 = sv;
        @(posedge clk); #1;
        iv32 = 1'b0; a32 = $urandom; b32 = $urandom; s32 = ~sv;
        lat = 0;
        while (!ov32 && lat < 100) begin @(posedge clk); #1; lat++; end
        r = res32;
        if (handshake) begin
            or32 = 1'b1;
            @(posedge clk); #1;
            or32 = 1'b0;
        end
    endtask

    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         output logic [31:0] r, output int lat);
        int guard = 0;
        while (!ir16 && guard < 100) begin @(posedge clk); #1; guard++; end
        iv16 = 1'b1; a16 = av; b16 = bv; s16 = sv;
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0;
        while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
        r = res16;
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
    endtask

    initial begin
        logic [63:0] r, held;
        logic [31:0] r16;
        int          lat;
        logic [15:0] ra, rb;
        logic        rs;
        bit          rose;

        resetn = 1'b0;
        iv32 = 0; a32 = 0; b32 = 0; s32 = 0; or32 = 0; fl32 = 0;
        iv16 = 0; a16 = 0; b16 = 0; s16 = 0; or16 = 0; fl16 = 0;
        #2;
        check("reset_in_ready", 64'(ir32), 64'd1);
        check("reset_out_valid", 64'(ov32), 64'd0);
        check("reset_result", res32, 64'd0);
        #20 resetn = 1'b1;
        @(posedge clk); #1;

        // Signed and unsigned corner products with exact latency
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, r, lat);
        check("signed_m1xm1", r, 64'h0000_0000_0000_0001);
        check("latency32", 64'(lat), 64'd32);
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, r, lat);
        check("unsigned_maxxmax", r, 64'hFFFF_FFFE_0000_0001);
        run32(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, r, lat);
        check("signed_minxmin", r, 64'h4000_0000_0000_0000);
        run32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, r, lat);
        check("signed_mixed", r, ref32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1));

        // Backpressure: result must hold in DONE and no new request may enter
        run32(32'd123456, 32'hFFFF_FF00, 1'b1, 1'b0, r, lat);
        held = ref32(32'd123456, 32'hFFFF_FF00, 1'b1);
        check("bp_result", r, held);
        iv32 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 64'(ov32), 64'd1);
            check("bp_result_stable", res32, held);
            check("bp_in_ready", 64'(ir32), 64'd0);
        end
        iv32 = 1'b0; or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
        check("bp_release_in_ready", 64'(ir32), 64'd1);
        check("bp_release_out_valid", 64'(ov32), 64'd0);
        check("bp_result_held_after_hs", res32, held);

        // Flush at the 5th CALC cycle; in_valid during flush is ignored
        iv32 = 1'b1; a32 = 32'd99; b32 = 32'd77; s32 = 1'b0;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        fl32 = 1'b1; iv32 = 1'b1;
        @(posedge clk); #1;
        fl32 = 1'b0; iv32 = 1'b0;
        check("flush_in_ready", 64'(ir32), 64'd1);
        check("flush_out_valid", 64'(ov32), 64'd0);
        rose = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (ov32) rose = 1'b1; end
        check("flush_no_out_valid", 64'(rose), 64'd0);
        run32(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, r, lat);
        check("after_flush_7xm3", r, 64'hFFFF_FFFF_FFFF_FFEB);

        // Asynchronous reset mid-CALC clears outputs without a clock edge
        iv32 = 1'b1; a32 = 32'd5; b32 = 32'd6; s32 = 1'b0;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #1 resetn = 1'b0;
        #1;
        check("areset_in_ready", 64'(ir32), 64'd1);
        check("areset_out_valid", 64'(ov32), 64'd0);
        check("areset_result", res32, 64'd0);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        run32(32'hDEAD_BEEF, 32'h0000_0003, 1'b0, 1'b1, r, lat);
        check("post_reset_product", r, ref32(32'hDEAD_BEEF, 32'h0000_0003, 1'b0));
        check("post_reset_latency", 64'(lat), 64'd32);

        // Randomized WIDTH=16, BPC=4 run with occasional corner operands
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'h8000;
                1: rb = 16'hFFFF;
                2: begin ra = 16'h0000; end
                3: begin ra = 16'h8000; rb = 16'h8000; end
                default: ;
            endcase
            run16(ra, rb, rs, r16, lat);
            check($sformatf("rand16_%0d", i), 64'(r16), 64'(ref16(ra, rb, rs)));
            check("latency16", 64'(lat), 64'd4);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
